pr_bus_arb: RTL and testbench
=============================

PR_BUS_ARB -- requirements
Module: pr_bus_arb

Interface
REQ-001 SHALL have parameter WIDTH, default 4: bus data width in bits.
REQ-002 SHALL have parameter NCH, default 4: number of requesting channels (2..16).
REQ-003 SHALL have parameter MAX_HOLD, default 8: maximum consecutive cycles one channel may own the bus (1..256).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port req  input  NCH  per-channel bus request, bit i = channel i.
REQ-007 SHALL have port data_in  input  NCH*WIDTH  packed channel data, channel i at bits [i*WIDTH +: WIDTH].
REQ-008 SHALL have port gnt  output  NCH  registered one-hot grant, all-zero when the bus is free.
REQ-009 SHALL have port sel  output  clog2(NCH)  registered index of the current owner, 0 when free.
REQ-010 SHALL have port valid  output  1  high while a channel owns the bus.
REQ-011 SHALL have port out  output  WIDTH  bus value: data_in slice of the owner when valid, else all zeros.

Function
REQ-012 SHALL implement a two-state machine, IDLE and OWNED; valid = (state == OWNED).
REQ-013 In IDLE, at a rising edge with req != 0, SHALL move to OWNED and register gnt/sel for the winning channel; grant visible the cycle after req is first sampled (1-cycle latency).
REQ-014 Winner SHALL be the first requesting channel scanning upward from ptr+1, modulo NCH (round robin); ptr = last owner.
REQ-015 In IDLE with req == 0, SHALL stay in IDLE with gnt = 0, sel = 0, and ptr unchanged.
REQ-016 out SHALL be combinational from registered sel and live data_in; changes in the owner's data_in appear on out in the same cycle.
REQ-017 In OWNED, a hold counter SHALL clear on entry and increment every cycle; width clog2(MAX_HOLD)+1, no wrap.
REQ-018 In OWNED, at an edge where req[sel] is sampled low, SHALL release: return to IDLE, gnt = 0, ptr = sel.
REQ-019 In OWNED, at an edge where the counter equals MAX_HOLD-1 and req[sel] is still high, SHALL force release identically; ownership never exceeds MAX_HOLD cycles.
REQ-020 After any release, SHALL spend exactly one cycle in IDLE (valid = 0, out = 0) before the next grant; no direct owner-to-owner handoff.
REQ-021 A force-released channel still requesting SHALL compete normally; it wins again only if no other channel requests.
REQ-022 Requests from non-owners during OWNED SHALL be ignored, not latched; only req levels at the IDLE decision edge count.
REQ-023 With MAX_HOLD = 1, every grant SHALL last exactly one cycle.
REQ-024 gnt SHALL always be one-hot or zero, and gnt[sel] = 1 whenever valid = 1.

Reset
REQ-025 rst high SHALL immediately, without a clock, force state IDLE, gnt = 0, sel = 0, valid = 0, out = 0, counter = 0, ptr = NCH-1 (channel 0 has first priority).
REQ-026 Reset asserted mid-ownership SHALL drop the grant at once; after release, the first grant follows REQ-013/REQ-014 from ptr = NCH-1.
REQ-027 On the first rising edge after rst deasserts, arbitration SHALL proceed normally.

Verification (WIDTH=4, NCH=4, MAX_HOLD=8)
REQ-028 Reset then req=0001, data_in=0x000A -> one edge later gnt=0001, sel=0, valid=1, out=0xA; drop req -> next edge valid=0, out=0x0.
REQ-029 Reset, req=1111 held; each owner drops its req after 2 cycles and re-raises it in IDLE -> grants in order 0,1,2,3,0, each followed by a 1-cycle IDLE gap.
REQ-030 req=0100 held for 20 cycles with data_in[11:8]=0x5 -> gnt=0100 for exactly 8 cycles, 1 cycle idle, regranted to channel 2, repeat; out=0x5 whenever valid.
REQ-031 Channel 1 owns with req=0110 held -> at timeout, channel 2 granted next, not channel 1.
REQ-032 Channel 3 owns, rst pulsed mid-cycle -> gnt=0000, valid=0, out=0 before the next edge; after release with req=1001, channel 0 is granted.
REQ-033 Owner data_in changes 0x3 -> 0xC mid-ownership -> out changes in the same cycle; non-owner data_in changes never affect out.

Source files
------------

// File: rtl/pr_bus_arb.sv
// -----------------------------------------------------------------------------
// pr_bus_arb
//   Round-robin bus arbiter with a bounded hold time. One channel at a time
//   owns the bus; ownership ends when the owner drops its request or after
//   MAX_HOLD consecutive cycles, and every release is followed by exactly one
//   idle cycle before the next grant.
//
// Parameters
//   WIDTH    : bus data width in bits
//   NCH      : number of requesting channels (2..16)
//   MAX_HOLD : maximum consecutive cycles one channel may own the bus (1..256)
//
// Ports
//   clk     : clock, all state changes on the rising edge
//   rst     : asynchronous active-high reset
//   req     : per-channel request, bit i = channel i
//   data_in : packed channel data, channel i at [i*WIDTH +: WIDTH]
//   gnt     : registered one-hot grant, zero when the bus is free
//   sel     : registered owner index, zero when the bus is free
//   valid   : high while a channel owns the bus
//   out     : owner's live data when valid, else zero
// -----------------------------------------------------------------------------
module pr_bus_arb #(
    parameter int WIDTH    = 4,
    parameter int NCH      = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NCH-1:0]           req,
    input  logic [NCH*WIDTH-1:0]     data_in,
    output logic [NCH-1:0]           gnt,
    output logic [$clog2(NCH)-1:0]   sel,
    output logic                     valid,
    output logic [WIDTH-1:0]         out
);

    localparam int SW = $clog2(NCH);
    localparam int CW = $clog2(MAX_HOLD) + 1;

    localparam logic [CW-1:0]  CNT_ONE   = CW'(1);
    localparam logic [CW-1:0]  CNT_LAST  = CW'(MAX_HOLD - 1);
    localparam logic [NCH-1:0] GNT_ONE   = NCH'(1);
    localparam logic [SW-1:0]  PTR_RESET = SW'(NCH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    state_t           state_r;
    logic [SW-1:0]    ptr_r;
    logic [SW-1:0]    sel_r;
    logic [NCH-1:0]   gnt_r;
    logic             valid_r;
    logic [CW-1:0]    cnt_r;

    logic [SW-1:0]    win_s;
    logic             release_s;
    logic [WIDTH-1:0] out_s;

    // First requesting channel strictly after p, wrapping modulo NCH. The scan
    // runs from the farthest candidate back to the nearest so that the nearest
    // requester is the last (and therefore winning) assignment.
    function automatic logic [SW-1:0] rr_pick(input logic [NCH-1:0] r,
                                              input logic [SW-1:0]  p);
        logic [SW-1:0] w;
        int            idx;
        w = {SW{1'b0}};
        for (int k = NCH; k >= 1; k--) begin
            idx = (int'(p) + k) % NCH;
            if (r[idx]) begin
                w = SW'(idx);
            end else begin
                w = w;
            end
        end
        return w;
    endfunction

    // Round-robin winner for the next IDLE decision edge.
    always_comb begin
        win_s = rr_pick(req, ptr_r);
    end

    // Owner gives up the bus on a dropped request or when its hold budget ends.
    always_comb begin
        release_s = 1'b0;
        release_s = (req[sel_r] == 1'b0) || (cnt_r == CNT_LAST);
    end

    // Arbitration state machine with registered grant, index and valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            gnt_r   <= {NCH{1'b0}};
            sel_r   <= {SW{1'b0}};
            valid_r <= 1'b0;
            cnt_r   <= {CW{1'b0}};
            ptr_r   <= PTR_RESET;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req != {NCH{1'b0}}) begin
                        state_r <= OWNED;
                        gnt_r   <= GNT_ONE << win_s;
                        sel_r   <= win_s;
                        valid_r <= 1'b1;
                        cnt_r   <= {CW{1'b0}};
                    end else begin
                        gnt_r   <= {NCH{1'b0}};
                        sel_r   <= {SW{1'b0}};
                        valid_r <= 1'b0;
                    end
                end
                OWNED: begin
                    if (release_s) begin
                        // Release always lands in IDLE: no owner-to-owner handoff.
                        state_r <= IDLE;
                        gnt_r   <= {NCH{1'b0}};
                        sel_r   <= {SW{1'b0}};
                        valid_r <= 1'b0;
                        cnt_r   <= {CW{1'b0}};
                        ptr_r   <= sel_r;
                    end else begin
                        cnt_r   <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    gnt_r   <= {NCH{1'b0}};
                    sel_r   <= {SW{1'b0}};
                    valid_r <= 1'b0;
                    cnt_r   <= {CW{1'b0}};
                end
            endcase
        end
    end

    // Bus mux: owner's live slice, OR-combined so a free bus reads zero.
    always_comb begin
        out_s = {WIDTH{1'b0}};
        for (int i = 0; i < NCH; i++) begin
            out_s = out_s | (data_in[i*WIDTH +: WIDTH] &
                             {WIDTH{valid_r && (sel_r == SW'(i))}});
        end
    end

    assign gnt   = gnt_r;
    assign sel   = sel_r;
    assign valid = valid_r;
    assign out   = out_s;

endmodule

// File: tb/tb_pr_bus_arb.sv
// -----------------------------------------------------------------------------
// tb_pr_bus_arb
//   Self-checking bench for pr_bus_arb (WIDTH=4, NCH=4, MAX_HOLD=8), plus a
//   second instance with MAX_HOLD=1 watched by directed checks. A cycle-level
//   ownership model (owner number, cycles held, last owner) predicts gnt, sel,
//   valid and out; a compare process checks them every falling edge.
// -----------------------------------------------------------------------------
module tb_pr_bus_arb;

    localparam int WIDTH    = 4;
    localparam int NCH      = 4;
    localparam int MAX_HOLD = 8;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [NCH-1:0]         req = 4'b0000;
    logic [NCH*WIDTH-1:0]   data_in = 16'h0000;
    logic [NCH-1:0]         gnt;
    logic [1:0]             sel;
    logic                   valid;
    logic [WIDTH-1:0]       out;
    logic [NCH-1:0]         gnt1;
    logic [1:0]             sel1;
    logic                   valid1;
    logic [WIDTH-1:0]       out1;

    int tests = 0;
    int fails = 0;

    // model state: owner (-1 = free), cycles owned so far, last owner
    int m_owner = -1;
    int m_hold  = 0;
    int m_ptr   = NCH - 1;

    pr_bus_arb #(.WIDTH(WIDTH), .NCH(NCH), .MAX_HOLD(MAX_HOLD)) u_dut (
        .clk(clk), .rst(rst), .req(req), .data_in(data_in),
        .gnt(gnt), .sel(sel), .valid(valid), .out(out)
    );

    pr_bus_arb #(.WIDTH(WIDTH), .NCH(NCH), .MAX_HOLD(1)) u_dut1 (
        .clk(clk), .rst(rst), .req(req), .data_in(data_in),
        .gnt(gnt1), .sel(sel1), .valid(valid1), .out(out1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int first_after(input logic [NCH-1:0] r, input int p);
        for (int k = 1; k <= NCH; k++) begin
            if (r[(p + k) % NCH]) return (p + k) % NCH;
        end
        return -1;
    endfunction

    // ownership model
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_owner <= -1;
            m_hold  <= 0;
            m_ptr   <= NCH - 1;
        end else if (m_owner < 0) begin
            if (req != 4'b0000) begin
                m_owner <= first_after(req, m_ptr);
                m_hold  <= 1;
            end
        end else if (!req[m_owner] || m_hold >= MAX_HOLD) begin
            m_ptr   <= m_owner;
            m_owner <= -1;
            m_hold  <= 0;
        end else begin
            m_hold  <= m_hold + 1;
        end
    end

    // per-cycle comparison against the model
    always @(negedge clk) begin
        logic [31:0] e_gnt, e_sel, e_val, e_out;
        if (m_owner < 0) begin
            e_gnt = 32'd0; e_sel = 32'd0; e_val = 32'd0; e_out = 32'd0;
        end else begin
            e_gnt = 32'd1 << m_owner;
            e_sel = 32'(m_owner);
            e_val = 32'd1;
            e_out = 32'((data_in >> (m_owner * WIDTH)) & 16'h000F);
        end
        check("model_gnt",   32'(gnt),   e_gnt);
        check("model_sel",   32'(sel),   e_sel);
        check("model_valid", 32'(valid), e_val);
        check("model_out",   32'(out),   e_out);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        step(2);
        check("reset_gnt",   32'(gnt),   32'd0);
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_out",   32'(out),   32'd0);
        rst = 1'b0;

        // single request, 1-cycle latency, release on drop
        req = 4'b0001; data_in = 16'h000A;
        step(1);
        check("single_gnt",   32'(gnt),   32'h1);
        check("single_sel",   32'(sel),   32'h0);
        check("single_valid", 32'(valid), 32'h1);
        check("single_out",   32'(out),   32'hA);
        req = 4'b0000;
        step(1);
        check("single_rel_valid", 32'(valid), 32'h0);
        check("single_rel_out",   32'(out),   32'h0);
        step(1);

        // round robin with all requesting, each owner keeps the bus 2 cycles
        do_reset();
        req = 4'b1111; data_in = 16'h4321;
        step(1);
        for (int i = 0; i < 5; i++) begin
            check("rr_gnt", 32'(gnt), 32'd1 << (i % 4));
            step(1);
            req[i % 4] = 1'b0;
            step(1);
            check("rr_gap_valid", 32'(valid), 32'h0);
            check("rr_gap_gnt",   32'(gnt),   32'h0);
            req = 4'b1111;
            step(1);
        end
        req = 4'b0000;
        step(2);

        // hold limit with a single requester; MAX_HOLD=1 copy alternates
        do_reset();
        data_in = 16'h0500; req = 4'b0100;
        for (int k = 1; k <= 20; k++) begin
            step(1);
            check("hold_valid", 32'(valid), (k == 9 || k == 18) ? 32'h0 : 32'h1);
            check("hold_out",   32'(out),   (k == 9 || k == 18) ? 32'h0 : 32'h5);
            check("hold1_valid", 32'(valid1), 32'(k % 2));
            check("hold1_gnt",   32'(gnt1),   (k % 2 == 1) ? 32'h4 : 32'h0);
        end
        req = 4'b0000;
        step(2);

        // forced release passes the bus to the other requester
        do_reset();
        req = 4'b0110;
        step(1);
        check("timeout_first_gnt", 32'(gnt), 32'h2);
        step(8);
        check("timeout_gap_valid", 32'(valid), 32'h0);
        step(1);
        check("timeout_next_gnt", 32'(gnt), 32'h4);
        req = 4'b0000;
        step(2);

        // reset mid-ownership drops the grant without a clock edge
        do_reset();
        data_in = 16'h7000; req = 4'b1000;
        step(1);
        check("pre_rst_gnt", 32'(gnt), 32'h8);
        check("pre_rst_out", 32'(out), 32'h7);
        #2 rst = 1'b1;
        #1;
        check("async_rst_gnt",   32'(gnt),   32'h0);
        check("async_rst_valid", 32'(valid), 32'h0);
        check("async_rst_out",   32'(out),   32'h0);
        req = 4'b1001;
        step(1);
        rst = 1'b0;
        step(1);
        check("post_rst_gnt", 32'(gnt), 32'h1);
        req = 4'b0000;
        step(2);

        // owner data is live; non-owner data never reaches out
        req = 4'b0010; data_in = 16'h0030;
        step(1);
        check("live_out_a", 32'(out), 32'h3);
        data_in = 16'h00C0;
        #1;
        check("live_out_b", 32'(out), 32'hC);
        data_in = 16'hFFCF;
        #1;
        check("live_out_c", 32'(out), 32'hC);
        req = 4'b0000;
        step(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
